// File: rtl/program_loader.sv
// Serial program loader: unpacks a framed UART byte stream into 12-bit words
// and writes them into the program RAM while holding the CPU.
module program_loader #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 12,
    parameter int unsigned BASE_ADDR  = 0,
    parameter logic [7:0]  SYNC_BYTE  = 8'hA5,
    parameter int unsigned TIMEOUT    = 100000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    output logic                  ram_we,
    output logic                  cpu_hold,
    output logic                  busy,
    output logic                  load_done,
    output logic                  load_err
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
    localparam int unsigned REM_W = 9;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COUNT,
        S_B0,
        S_B1,
        S_B2,
        S_CHK
    } state_t;

    state_t                state_q, state_d;
    logic [REM_W-1:0]      rem_q, rem_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            sum_q, sum_d;
    logic [7:0]            b0_q, b0_d;
    logic [3:0]            b1lo_q, b1lo_d;
    logic [TMO_W-1:0]      tmo_q, tmo_d;
    logic [ADDR_WIDTH-1:0] ram_addr_d;
    logic [DATA_WIDTH-1:0] ram_din_d;
    logic                  ram_we_d, cpu_hold_d, busy_d, load_done_d, load_err_d;

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            rem_q     <= '0;
            addr_q    <= '0;
            sum_q     <= '0;
            b0_q      <= '0;
            b1lo_q    <= '0;
            tmo_q     <= '0;
            ram_addr  <= '0;
            ram_din   <= '0;
            ram_we    <= 1'b0;
            cpu_hold  <= 1'b0;
            busy      <= 1'b0;
            load_done <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            addr_q    <= addr_d;
            sum_q     <= sum_d;
            b0_q      <= b0_d;
            b1lo_q    <= b1lo_d;
            tmo_q     <= tmo_d;
            ram_addr  <= ram_addr_d;
            ram_din   <= ram_din_d;
            ram_we    <= ram_we_d;
            cpu_hold  <= cpu_hold_d;
            busy      <= busy_d;
            load_done <= load_done_d;
            load_err  <= load_err_d;
        end
    end

    // Frame parser, word unpacking, checksum and inter-byte timeout
    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        addr_d      = addr_q;
        sum_d       = sum_q;
        b0_d        = b0_q;
        b1lo_d      = b1lo_q;
        tmo_d       = '0;
        ram_addr_d  = ram_addr;
        ram_din_d   = ram_din;
        ram_we_d    = 1'b0;
        load_done_d = load_done;
        load_err_d  = load_err;

        // Idle cycles since the last byte; only counted inside a frame
        if (state_q != S_IDLE && !rx_valid) begin
            tmo_d = tmo_q + TMO_W'(1);
        end

        if (rx_valid) begin
            case (state_q)
                S_IDLE: begin
                    if (rx_data == SYNC_BYTE) begin
                        state_d     = S_COUNT;
                        load_done_d = 1'b0;
                        load_err_d  = 1'b0;
                    end
                end
                S_COUNT: begin
                    rem_d   = (rx_data == 8'h00) ? REM_W'(256) : REM_W'(rx_data);
                    addr_d  = ADDR_WIDTH'(BASE_ADDR);
                    sum_d   = '0;
                    state_d = S_B0;
                end
                S_B0: begin
                    b0_d    = rx_data;
                    sum_d   = sum_q + rx_data;
                    state_d = S_B1;
                end
                S_B1: begin
                    sum_d      = sum_q + rx_data;
                    b1lo_d     = rx_data[3:0];
                    ram_we_d   = 1'b1;
                    ram_addr_d = addr_q;
                    ram_din_d  = DATA_WIDTH'({b0_q, rx_data[7:4]});
                    addr_d     = addr_q + ADDR_WIDTH'(1);
                    rem_d      = rem_q - REM_W'(1);
                    state_d    = (rem_q == REM_W'(1)) ? S_CHK : S_B2;
                end
                S_B2: begin
                    sum_d      = sum_q + rx_data;
                    ram_we_d   = 1'b1;
                    ram_addr_d = addr_q;
                    ram_din_d  = DATA_WIDTH'({b1lo_q, rx_data});
                    addr_d     = addr_q + ADDR_WIDTH'(1);
                    rem_d      = rem_q - REM_W'(1);
                    state_d    = (rem_q == REM_W'(1)) ? S_CHK : S_B0;
                end
                S_CHK: begin
                    state_d = S_IDLE;
                    if (rx_data == sum_q) begin
                        load_done_d = 1'b1;
                    end else begin
                        load_err_d = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end else if (state_q != S_IDLE && tmo_q == TMO_W'(TIMEOUT - 1)) begin
            // TIMEOUT cycles without a byte: abandon the frame
            state_d    = S_IDLE;
            load_err_d = 1'b1;
            tmo_d      = '0;
        end

        busy_d     = (state_d != S_IDLE);
        cpu_hold_d = busy_d;
    end

endmodule

// File: tb/tb_program_loader.sv
// Randomized scoreboard bench for program_loader; two instances (base 0 and 8)
// share the same byte stream.
module tb_program_loader;

    localparam int unsigned TB_TIMEOUT = 40;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_valid;

    logic [7:0]  ram_addr0, ram_addr1;
    logic [11:0] ram_din0, ram_din1;
    logic        ram_we0, ram_we1, cpu_hold0, cpu_hold1, busy0, busy1;
    logic        done0, done1, err0, err1;

    typedef struct {
        logic [7:0]  a;
        logic [11:0] d;
    } wr_t;

    wr_t        q0[$];
    wr_t        q1[$];
    wr_t        e0, e1;
    logic [7:0] pay[$];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    program_loader #(.BASE_ADDR(0), .TIMEOUT(TB_TIMEOUT)) u0 (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .ram_addr(ram_addr0), .ram_din(ram_din0), .ram_we(ram_we0),
        .cpu_hold(cpu_hold0), .busy(busy0), .load_done(done0), .load_err(err0)
    );

    program_loader #(.BASE_ADDR(8), .TIMEOUT(TB_TIMEOUT)) u1 (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .ram_addr(ram_addr1), .ram_din(ram_din1), .ram_we(ram_we1),
        .cpu_hold(cpu_hold1), .busy(busy1), .load_done(done1), .load_err(err1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor for the base-0 instance
    always @(posedge clk) begin
        #1;
        if (ram_we0 === 1'b1) begin
            if (q0.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL wr0_unexpected actual=addr %0h data %0h required=no write", ram_addr0, ram_din0);
            end else begin
                e0 = q0.pop_front();
                check("wr0_addr", 32'(ram_addr0), 32'(e0.a));
                check("wr0_data", 32'(ram_din0), 32'(e0.d));
            end
        end
    end

    // Scoreboard monitor for the base-8 instance
    always @(posedge clk) begin
        #1;
        if (ram_we1 === 1'b1) begin
            if (q1.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL wr1_unexpected actual=addr %0h data %0h required=no write", ram_addr1, ram_din1);
            end else begin
                e1 = q1.pop_front();
                check("wr1_addr", 32'(ram_addr1), 32'(e1.a));
                check("wr1_data", 32'(ram_din1), 32'(e1.d));
            end
        end
    end

    // Called at a falling edge; drives one byte for one cycle then idles gap cycles
    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic fill_random(input int n_words);
        int nbytes;
        nbytes = 3 * (n_words / 2) + 2 * (n_words % 2);
        pay.delete();
        for (int i = 0; i < nbytes; i++) pay.push_back(8'($urandom));
    endtask

    task automatic check_status(input string tag, input logic d, input logic e, input logic b);
        check({tag, "_done0"}, 32'(done0), 32'(d));
        check({tag, "_err0"},  32'(err0),  32'(e));
        check({tag, "_busy0"}, 32'(busy0), 32'(b));
        check({tag, "_hold0"}, 32'(cpu_hold0), 32'(b));
        check({tag, "_done1"}, 32'(done1), 32'(d));
        check({tag, "_busy1"}, 32'(busy1), 32'(b));
    endtask

    // Reference: words and checksum from the frame rules, then drive the frame
    task automatic send_frame(input logic [7:0] cnt, input bit good, input int min_gap, input int max_gap);
        int         n;
        logic [7:0] sum;
        logic [7:0] chk;
        logic [11:0] w;
        int         g;
        n   = (cnt == 8'h00) ? 256 : int'(cnt);
        sum = 8'h00;
        foreach (pay[i]) sum = sum + pay[i];
        for (int i = 0; i < n; i++) begin
            g = i / 2;
            if (i % 2 == 0) w = {pay[3*g], pay[3*g+1][7:4]};
            else            w = {pay[3*g+1][3:0], pay[3*g+2]};
            q0.push_back('{a: 8'(i), d: w});
            q1.push_back('{a: 8'(i + 8), d: w});
        end
        chk = good ? sum : sum + 8'h3C;
        send_byte(8'hA5, 0);
        check_status("sync", 1'b0, 1'b0, 1'b1);
        send_byte(cnt, $urandom_range(max_gap, min_gap));
        foreach (pay[i]) send_byte(pay[i], $urandom_range(max_gap, min_gap));
        send_byte(chk, 0);
        check_status(good ? "end_good" : "end_bad", good, !good, 1'b0);
        @(negedge clk);
        check("q0_drained", 32'(q0.size()), 32'd0);
        check("q1_drained", 32'(q1.size()), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_we", 32'(ram_we0), 32'd0);
        check("rst_addr", 32'(ram_addr0), 32'd0);
        check("rst_din", 32'(ram_din0), 32'd0);
        check_status("rst", 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // Good, odd-count and bad-checksum frames
        pay = '{8'h0F, 8'h90, 8'h90};
        send_frame(8'h02, 1'b1, 0, 0);
        pay = '{8'h9F, 8'h1C};
        send_frame(8'h01, 1'b1, 0, 0);
        pay = '{8'h0F, 8'h90, 8'h90};
        send_frame(8'h02, 1'b0, 0, 1);

        // Timeout mid-frame, then a stray byte is ignored
        send_byte(8'hA5, 0);
        send_byte(8'h02, 0);
        send_byte(8'h0F, 0);
        repeat (TB_TIMEOUT + 5) @(negedge clk);
        check_status("timeout", 1'b0, 1'b1, 1'b0);
        send_byte(8'h55, 0);
        check("stray_busy", 32'(busy0), 32'd0);
        check("stray_err", 32'(err0), 32'd1);

        // Gaps just under the timeout limit must not abort
        fill_random(3);
        send_frame(8'h03, 1'b1, TB_TIMEOUT - 3, TB_TIMEOUT - 2);

        // Full 256-word load, back-to-back bytes; base 8 wraps
        fill_random(256);
        send_frame(8'h00, 1'b1, 0, 0);

        // Random frames
        for (int k = 0; k < 8; k++) begin
            int n;
            n = $urandom_range(20, 1);
            fill_random(n);
            send_frame(8'(n), ($urandom_range(3, 0) != 0), 0, 2);
        end

        // Reset after the first word of a 4-word frame
        fill_random(4);
        q0.push_back('{a: 8'h00, d: {pay[0], pay[1][7:4]}});
        q1.push_back('{a: 8'h08, d: {pay[0], pay[1][7:4]}});
        send_byte(8'hA5, 0);
        send_byte(8'h04, 0);
        send_byte(pay[0], 0);
        send_byte(pay[1], 0);
        @(negedge clk);
        check("pre_rst_q0", 32'(q0.size()), 32'd0);
        check("pre_rst_busy", 32'(busy0), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_we", 32'(ram_we0), 32'd0);
        check("arst_addr", 32'(ram_addr0), 32'd0);
        check("arst_din", 32'(ram_din0), 32'd0);
        check_status("arst", 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        fill_random(3);
        send_frame(8'h03, 1'b1, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Serial program loader sitting directly upstream of the 256x12 program RAM.
- Accepts a byte stream from the UART receiver and unpacks it into 12-bit instruction words.
- Writes each word into the RAM through its addr/din/write_en port.
- Holds the CPU while loading, then reports done or error. Allows the CPU program to be replaced without resynthesis.

Parameters:
ADDR_WIDTH, 8, RAM address width; addresses wrap modulo 2^ADDR_WIDTH
DATA_WIDTH, 12, RAM word width; fixed at 12 by the packing scheme
BASE_ADDR, 0, RAM address of the first loaded word
SYNC_BYTE, 8'hA5, frame start marker
TIMEOUT, 100000, max clk cycles between bytes inside a frame (>=2)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
rx_data  in  8  received byte, valid only when rx_valid=1
rx_valid  in  1  one-cycle strobe per byte; no backpressure, loader accepts every strobe
ram_addr  out  ADDR_WIDTH  RAM write address
ram_din  out  DATA_WIDTH  RAM write data
ram_we  out  1  RAM write enable, one-cycle pulse per word
cpu_hold  out  1  1 = CPU held in reset/stall while a frame is in progress
busy  out  1  1 in any state other than IDLE
load_done  out  1  sticky: last frame completed with good checksum
load_err  out  1  sticky: last frame failed (checksum or timeout)

Behaviour:
- Reset (async, rst_n=0) forces all outputs to 0, state to IDLE, and clears the address counter, checksum, and timeout counter. Reset mid-frame abandons the frame; words already written stay in RAM.
- Frame format: SYNC_BYTE, COUNT, payload, CHK.
  - Word count N = COUNT, except COUNT=0 means N=256.
  - Payload is packed in 3-byte groups b0,b1,b2 -> w0={b0,b1[7:4]}, w1={b1[3:0],b2}.
  - If N is odd, the final group has only b0,b1; it yields w0 only, and b1[3:0] is ignored.
  - CHK = (sum of all payload bytes) mod 256. COUNT is not included.
- States: IDLE, COUNT, B0, B1, B2, CHK.
- IDLE:
  - rx_valid with rx_data==SYNC_BYTE -> COUNT. Same cycle: clear load_done and load_err; next cycle cpu_hold=1.
  - Other bytes are ignored.
- COUNT: on byte -> latch N, set remaining=N, addr=BASE_ADDR, sum=0 -> B0.
- B0: on byte -> store b0, sum+=byte -> B1.
- B1: on byte -> sum+=byte, store b1, issue write w0, remaining-=1.
  - remaining becomes 0 -> CHK; else -> B2.
- B2: on byte -> sum+=byte, issue write w1, remaining-=1.
  - remaining becomes 0 -> CHK; else -> B0.
- CHK: on byte -> IDLE.
  - byte==sum: load_done=1.
  - byte!=sum: load_err=1.
  - cpu_hold=0 the next cycle in both cases.
- Write timing:
  - "issue write" means the cycle after the accepting rx_valid: ram_we=1, ram_addr=current addr, ram_din=word.
  - addr increments by 1 after each write, wrapping modulo 2^ADDR_WIDTH.
  - ram_we=0 otherwise; ram_addr/ram_din hold their last value.
  - At most one write per accepted byte, so back-to-back rx_valid every cycle is supported.
- Timeout:
  - The counter runs in COUNT..CHK and resets on each rx_valid.
  - On reaching TIMEOUT -> IDLE, load_err=1, cpu_hold=0.
- A SYNC_BYTE value received inside a frame is treated as data (no resync).
- busy = (state != IDLE), registered.
- cpu_hold equals busy delayed by 0 cycles after the SYNC accept register update, i.e. both rise on the same edge.

Test Plan:
- Good frame: A5,02,0F,90,90,2F -> writes addr0=0x0F9 then addr1=0x090 (one ram_we pulse each, the cycle after bytes 4 and 5); load_done=1, load_err=0, cpu_hold back to 0.
- Odd count: A5,01,9F,1C,BB -> single write addr0=0x9F1; the 0xC nibble is dropped but counted in the checksum; load_done=1.
- Bad checksum: A5,02,0F,90,90,00 -> both words still written; load_err=1, load_done=0, cpu_hold=0.
- Timeout: A5,02,0F then no bytes for TIMEOUT cycles -> no writes, load_err=1, state IDLE; a following 55 byte is ignored (busy stays 0).
- Full load, COUNT=00, 384 payload bytes sent with rx_valid every cycle:
  - Exactly 256 writes, addresses 0..255, each ram_we 1 cycle.
  - Correct CHK -> load_done=1.
  - Rerun with BASE_ADDR=8: addresses 8..255 then 0..7.
- Reset mid-frame: drop rst_n after word 1 of a 4-word frame -> all outputs 0 immediately (async). A new A5 frame after release loads starting at BASE_ADDR.
